// File: rtl/eth_tx_sched_pkg.sv
// Shared constants and state encoding for the RGMII TX frame scheduler.
// Also used by the round-robin arbiter for index sizing.
package eth_tx_sched_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] PAD_BYTE      = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_PAY,
    S_PAD,
    S_IFG
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
// Pointer only moves when the caller commits a grant via advance.
module rr_arbiter
  import eth_tx_sched_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;
  int            j;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(N - 1);
    end else if (advance) begin
      ptr <= gnt_idx;
    end
  end

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    cand       = '0;
    j          = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + 1 + i;
      if (j >= N) j = j - N;
      cand = IW'(j);
      if (!found && req[cand]) begin
        found            = 1'b1;
        gnt_onehot[cand] = 1'b1;
        gnt_idx          = cand;
      end
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Frame scheduler for the RGMII TX lane: RR grant, preamble/SFD,
// payload pull, zero-pad, error byte on underrun/truncation, then IFG.
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter  int N_REQ        = 2,
  parameter  int PREAMBLE_LEN = 7,
  parameter  int IFG_LEN      = 12,
  parameter  int MIN_PAYLOAD  = 64,
  parameter  int MAX_PAYLOAD  = 1518,
  localparam int IW           = idx_w(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  output logic [N_REQ-1:0]   o_gnt,
  output logic               o_rd,
  input  logic [8*N_REQ-1:0] i_data,
  input  logic [N_REQ-1:0]   i_valid,
  input  logic [N_REQ-1:0]   i_last,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_en,
  output logic               o_tx_er,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_abort
);

  state_t           state;
  logic [15:0]      cnt;
  logic [15:0]      cnt_nx;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    arb_idx;
  logic [N_REQ-1:0] arb_gnt;
  logic             ifg_end;
  logic             start;
  logic             pad_done;
  logic             max_hit;
  logic [7:0]       lane_data;
  logic             lane_valid;
  logic             lane_last;

  assign cnt_nx     = cnt + 16'd1;
  assign ifg_end    = (state == S_IFG) && (int'(cnt) == IFG_LEN);
  assign start      = ((state == S_IDLE) || ifg_end) && (|i_req);
  assign pad_done   = int'(cnt_nx) >= MIN_PAYLOAD;
  assign max_hit    = int'(cnt_nx) == MAX_PAYLOAD;
  assign lane_data  = i_data[{gidx, 3'b000} +: 8];
  assign lane_valid = i_valid[gidx];
  assign lane_last  = i_last[gidx];

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk        (i_clk),
    .rst        (i_rst),
    .req        (i_req),
    .advance    (start),
    .gnt_onehot (arb_gnt),
    .gnt_idx    (arb_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      gidx         <= '0;
      o_gnt        <= '0;
      o_rd         <= 1'b0;
      o_tx_data    <= 8'h00;
      o_tx_en      <= 1'b0;
      o_tx_er      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_abort      <= 1'b0;
      o_tx_er      <= 1'b0;
      unique case (state)
        S_IDLE: begin
        end
        S_PRE: begin
          if (int'(cnt) == PREAMBLE_LEN) begin
            o_tx_data <= SFD_BYTE;
            o_rd      <= 1'b1;
            cnt       <= '0;
            state     <= S_SFD;
          end else begin
            o_tx_data <= PREAMBLE_BYTE;
            cnt       <= cnt_nx;
          end
        end
        // SFD cycle already pulls the first payload byte
        S_SFD, S_PAY: begin
          if (!o_rd || !lane_valid) begin
            o_tx_data <= PAD_BYTE;
            o_tx_er   <= 1'b1;
            o_abort   <= 1'b1;
            o_rd      <= 1'b0;
            cnt       <= '0;
            state     <= S_IFG;
          end else begin
            o_tx_data <= lane_data;
            cnt       <= cnt_nx;
            state     <= S_PAY;
            if (lane_last) begin
              o_rd <= 1'b0;
              if (pad_done) begin
                o_frame_done <= 1'b1;
                cnt          <= '0;
                state        <= S_IFG;
              end else begin
                state <= S_PAD;
              end
            end else if (max_hit) begin
              o_rd <= 1'b0;
            end
          end
        end
        S_PAD: begin
          o_tx_data <= PAD_BYTE;
          cnt       <= cnt_nx;
          if (pad_done) begin
            o_frame_done <= 1'b1;
            cnt          <= '0;
            state        <= S_IFG;
          end
        end
        S_IFG: begin
          o_tx_en   <= 1'b0;
          o_tx_data <= 8'h00;
          o_gnt     <= '0;
          cnt       <= cnt_nx;
          if (ifg_end) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (start) begin
        state     <= S_PRE;
        gidx      <= arb_idx;
        o_gnt     <= arb_gnt;
        o_rd      <= 1'b0;
        o_tx_en   <= 1'b1;
        o_tx_data <= PREAMBLE_BYTE;
        o_busy    <= 1'b1;
        cnt       <= 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_sched.sv
// Randomized bench for eth_tx_sched: requester models plus a
// frame-level reference stream compared cycle by cycle.
module tb_eth_tx_sched;

  localparam int PL   = 7;
  localparam int IFG  = 12;
  localparam int MINP = 64;
  localparam int MAXP = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic        rd;
  logic [15:0] data;
  logic [1:0]  valid;
  logic [1:0]  last;
  logic [7:0]  tx_data;
  logic        en;
  logic        er;
  logic        busy;
  logic        done;
  logic        abort;

  always #4 clk = ~clk;

  eth_tx_sched #(
    .N_REQ(2), .PREAMBLE_LEN(PL), .IFG_LEN(IFG),
    .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .o_gnt        (gnt),
    .o_rd         (rd),
    .i_data       (data),
    .i_valid      (valid),
    .i_last       (last),
    .o_tx_data    (tx_data),
    .o_tx_en      (en),
    .o_tx_er      (er),
    .o_busy       (busy),
    .o_frame_done (done),
    .o_abort      (abort)
  );

  int          n_chk;
  int          n_pass;
  bit   [7:0]  mem [2][256];
  int          len_c [2];
  int          und_c [2];
  bit          hl_c [2];
  int          pos [2];
  bit          vld_drv [2];
  bit          rd_prev;
  logic [1:0]  gnt_prev;
  logic [1:0]  req_r;
  bit          cap_on;
  logic [13:0] cap [$];
  logic [13:0] expq [$];
  int          last_win;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  task automatic tick();
    @(negedge clk);
    if (cap_on) cap.push_back({gnt, done, abort, en, er, tx_data});
    for (int k = 0; k < 2; k++) begin
      if (rd_prev && gnt_prev[k] && vld_drv[k]) pos[k]++;
      if (gnt[k] === 1'b1) req_r[k] = 1'b0;
    end
    rd_prev  = rd;
    gnt_prev = gnt;
    for (int k = 0; k < 2; k++) begin
      vld_drv[k]     = (pos[k] != und_c[k]);
      valid[k]       = vld_drv[k];
      last[k]        = hl_c[k] && (pos[k] == len_c[k] - 1);
      data[8*k +: 8] = mem[k][pos[k] & 255];
    end
    req = req_r;
  endtask

  task automatic setup(input int k, input int len, input bit hl,
                       input int u, input bit seq);
    for (int i = 0; i < 256; i++)
      mem[k][i] = seq ? 8'(i) : 8'($urandom);
    len_c[k] = len;
    hl_c[k]  = hl;
    und_c[k] = u;
    pos[k]   = 0;
    req_r[k] = 1'b1;
  endtask

  // Expected lane bytes for one frame plus its gap: {gnt,done,abort,en,er,data}
  function automatic void add_frame(input int k);
    logic [1:0]  g;
    logic [13:0] r;
    g = 2'b01 << k;
    for (int i = 0; i < PL; i++) expq.push_back({g, 4'b0010, 8'h55});
    expq.push_back({g, 4'b0010, 8'hD5});
    for (int i = 0; i < 4096; i++) begin
      if (i == und_c[k]) begin
        expq.push_back({g, 4'b0111, 8'h00});
        break;
      end
      expq.push_back({g, 4'b0010, mem[k][i & 255]});
      if (hl_c[k] && i == len_c[k] - 1) begin
        for (int p = i + 1; p < MINP; p++)
          expq.push_back({g, 4'b0010, 8'h00});
        r = expq.pop_back();
        r[11] = 1'b1;
        expq.push_back(r);
        break;
      end
      if (i + 1 == MAXP) begin
        expq.push_back({g, 4'b0111, 8'h00});
        break;
      end
    end
    for (int i = 0; i < IFG; i++) expq.push_back(14'h0);
  endfunction

  task automatic run(input logic [1:0] mask, input string tag);
    logic [1:0] m;
    int         w;
    int         n;
    expq.delete();
    m = mask;
    while (m != 2'b00) begin
      w = m[(last_win + 1) % 2] ? (last_win + 1) % 2 : last_win;
      add_frame(w);
      m[w]     = 1'b0;
      last_win = w;
    end
    cap.delete();
    tick();
    cap_on = 1'b1;
    n = 0;
    while (cap.size() < expq.size() && n < 3000) begin
      tick();
      n++;
    end
    cap_on = 1'b0;
    chk({tag, "_len"}, cap.size(), expq.size());
    for (int i = 0; i < expq.size() && i < cap.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), cap[i], expq[i]);
    tick();
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_en_end"}, en, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_r = 2'b00;
    for (int k = 0; k < 2; k++) begin
      hl_c[k] = 1'b0; und_c[k] = -1; pos[k] = 0; len_c[k] = 1;
    end
    tick();
    tick();
    rst = 1'b0;
    rd_prev  = 1'b0;
    gnt_prev = 2'b00;
    last_win = 1;
  endtask

  initial begin
    logic [1:0] mk;
    int         ln;
    n_chk = 0; n_pass = 0; cap_on = 1'b0;
    req = '0; valid = '0; last = '0; data = '0;
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_tx_en", en, 1'b0);
    chk("rst_tx_er", er, 1'b0);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_rd", rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_abort", abort, 1'b0);
    do_reset();

    setup(0, 64, 1'b1, -1, 1'b1);
    run(2'b01, "t1_single");

    do_reset();
    setup(0, $urandom_range(20, 90), 1'b1, -1, 1'b0);
    setup(1, $urandom_range(20, 90), 1'b1, -1, 1'b0);
    run(2'b11, "t2_both");

    setup(0, 10, 1'b1, -1, 1'b0);
    run(2'b01, "t3_pad");

    setup(0, 50, 1'b1, 20, 1'b0);
    setup(1, 30, 1'b1, -1, 1'b0);
    run(2'b11, "t4_underrun");

    setup(1, 1, 1'b0, -1, 1'b0);
    run(2'b10, "t5_trunc");

    setup(0, 60, 1'b1, -1, 1'b0);
    tick();
    for (int i = 0; i < 25; i++) tick();
    chk("t6_in_frame", en, 1'b1);
    rst = 1'b1;
    tick();
    chk("t6_rst_en", en, 1'b0);
    chk("t6_rst_gnt", gnt, 2'b00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_abort", abort, 1'b0);
    do_reset();
    setup(0, $urandom_range(1, 80), 1'b1, -1, 1'b0);
    setup(1, $urandom_range(1, 80), 1'b1, -1, 1'b0);
    run(2'b11, "t6_after");

    for (int it = 0; it < 8; it++) begin
      mk = 2'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        if (mk[k]) begin
          ln = $urandom_range(1, 110);
          setup(k, ln, $urandom_range(0, 9) != 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ln)) : -1,
                1'b0);
        end
      end
      run(mk, $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
